// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared widths, month encodings and month-length constants for the calendar counter
package cal_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YMOD_W  = 2;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [DAY_W-1:0] DIM_31       = 5'd31;
    localparam logic [DAY_W-1:0] DIM_30       = 5'd30;
    localparam logic [DAY_W-1:0] DIM_FEB      = 5'd28;
    localparam logic [DAY_W-1:0] DIM_FEB_LEAP = 5'd29;

endpackage

// File: rtl/month_len_lut.sv
// rtl/month_len_lut.sv - combinational month length lookup (days in month, 31-day flag, February flag)
module month_len_lut
    import cal_pkg::*;
#(
    parameter int LEAP_EN = 1
) (
    input  logic [MONTH_W-1:0] i_month,
    input  logic [YMOD_W-1:0]  i_ymod,
    output logic [DAY_W-1:0]   o_dim,
    output logic               o_day30_31,
    output logic               o_feb
);

    // Out-of-range months report 31 days; callers range-check the month themselves.
    always_comb begin
        o_dim      = DIM_31;
        o_day30_31 = 1'b0;
        o_feb      = 1'b0;
        case (i_month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: begin
                o_dim      = DIM_31;
                o_day30_31 = 1'b1;
            end
            APR, JUN, SEP, NOV: begin
                o_dim = DIM_30;
            end
            FEB: begin
                o_feb = 1'b1;
                o_dim = ((LEAP_EN != 0) && (i_ymod == '0)) ? DIM_FEB_LEAP : DIM_FEB;
            end
            default: begin
                o_dim = DIM_31;
            end
        endcase
    end

endmodule

// File: rtl/day_calendar_counter.sv
// rtl/day_calendar_counter.sv - calendar date register advanced by tick strobes, with validated parallel load
module day_calendar_counter
    import cal_pkg::*;
#(
    parameter int                 LEAP_EN    = 1,
    parameter logic [YMOD_W-1:0]  RESET_YMOD = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_load,
    input  logic [DAY_W-1:0]   i_load_day,
    input  logic [MONTH_W-1:0] i_load_month,
    input  logic [YMOD_W-1:0]  i_load_ymod,
    output logic [DAY_W-1:0]   o_today,
    output logic [MONTH_W-1:0] o_month,
    output logic [YMOD_W-1:0]  o_ymod,
    output logic               o_day30_31,
    output logic               o_feb,
    output logic [DAY_W-1:0]   o_dim,
    output logic               o_upd,
    output logic               o_load_err
);

    logic [DAY_W-1:0]   r_today;
    logic [MONTH_W-1:0] r_month;
    logic [YMOD_W-1:0]  r_ymod;
    logic               r_upd;
    logic               r_load_err;

    logic [DAY_W-1:0]   w_dim;
    logic               w_day30_31;
    logic               w_feb;
    logic [DAY_W-1:0]   w_ld_dim;
    logic               w_ld_day30_31;
    logic               w_ld_feb;
    logic               w_load_ok;
    logic               w_last_day;
    logic               w_last_month;

    month_len_lut #(.LEAP_EN(LEAP_EN)) u_cur_len (
        .i_month    (r_month),
        .i_ymod     (r_ymod),
        .o_dim      (w_dim),
        .o_day30_31 (w_day30_31),
        .o_feb      (w_feb)
    );

    // Load validation looks at the incoming month/ymod, never the current date.
    month_len_lut #(.LEAP_EN(LEAP_EN)) u_load_len (
        .i_month    (i_load_month),
        .i_ymod     (i_load_ymod),
        .o_dim      (w_ld_dim),
        .o_day30_31 (w_ld_day30_31),
        .o_feb      (w_ld_feb)
    );

    assign w_load_ok = (i_load_month >= JAN) && (i_load_month <= DEC) &&
                       (i_load_day != '0) && (i_load_day <= w_ld_dim);

    assign w_last_day   = (r_today >= w_dim);
    assign w_last_month = (r_month >= DEC);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_today    <= 5'd1;
            r_month    <= JAN;
            r_ymod     <= RESET_YMOD;
            r_upd      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_upd      <= 1'b0;
            r_load_err <= 1'b0;
            // A load always wins; a same-cycle tick is dropped even if the load is rejected.
            if (i_load) begin
                if (w_load_ok) begin
                    r_today <= i_load_day;
                    r_month <= i_load_month;
                    r_ymod  <= i_load_ymod;
                    r_upd   <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (i_tick) begin
                r_upd <= 1'b1;
                if (!w_last_day) begin
                    r_today <= r_today + 5'd1;
                end else begin
                    r_today <= 5'd1;
                    if (w_last_month) begin
                        r_month <= JAN;
                        r_ymod  <= r_ymod + 2'd1;
                    end else begin
                        r_month <= r_month + 4'd1;
                    end
                end
            end
        end
    end

    assign o_today    = r_today;
    assign o_month    = r_month;
    assign o_ymod     = r_ymod;
    assign o_day30_31 = w_day30_31;
    assign o_feb      = w_feb;
    assign o_dim      = w_dim;
    assign o_upd      = r_upd;
    assign o_load_err = r_load_err;

endmodule
